// File: rtl/aplic_msi_pkg.sv
// Shared types and constants for the APLIC MSI write initiator.
// Provides FSM states, AXI field constants, default AXI structs and the IMSIC address helper.
package aplic_msi_pkg;

  localparam int unsigned AXI_AW = 64;
  localparam int unsigned AXI_DW = 64;
  localparam int unsigned AXI_IW = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND   = 2'd1,
    WAIT_B = 2'd2
  } state_e;

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_4B    = 3'b010;

  typedef struct packed {
    logic [AXI_IW-1:0] id;
    logic [AXI_AW-1:0] addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
    logic              lock;
    logic [3:0]        cache;
    logic [2:0]        prot;
    logic [3:0]        qos;
    logic [3:0]        region;
  } ax_chan_t;

  typedef struct packed {
    logic [AXI_DW-1:0]   data;
    logic [AXI_DW/8-1:0] strb;
    logic                last;
  } w_chan_t;

  typedef struct packed {
    logic [AXI_IW-1:0] id;
    logic [1:0]        resp;
  } b_chan_t;

  typedef struct packed {
    logic [AXI_IW-1:0] id;
    logic [AXI_DW-1:0] data;
    logic [1:0]        resp;
    logic              last;
  } r_chan_t;

  typedef struct packed {
    ax_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ax_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } axi_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } axi_resp_t;

  // Byte offset of an interrupt file from the first page: hart group plus 4 KiB page per guest.
  function automatic logic [63:0] msi_offset(logic [63:0] hart, logic [63:0] guest,
                                             int unsigned stride_log2);
    return (hart << stride_log2) + (guest << 12);
  endfunction

endpackage

// File: rtl/aplic_msi_tx.sv
// APLIC-side MSI write initiator: one single-beat AXI write to an IMSIC seteipnum_le register per request.
// Optional B-wait timeout flag enabled by defining APLIC_MSI_TIMEOUT_EN.
module aplic_msi_tx
  import aplic_msi_pkg::*;
#(
  parameter int unsigned AXI_ADDR_WIDTH   = 64,
  parameter int unsigned AXI_DATA_WIDTH   = 64,
  parameter int unsigned AXI_ID_WIDTH     = 4,
  parameter logic [AXI_ID_WIDTH-1:0] AXI_ID = '0,
  parameter int unsigned NR_HARTS         = 1,
  parameter int unsigned NR_GUESTS        = 1,
  parameter int unsigned EIID_WIDTH       = 11,
  parameter logic [63:0] BASE_ADDR        = 64'h2400_0000,
  parameter int unsigned HART_STRIDE_LOG2 = 15,
  parameter int unsigned TIMEOUT_CYCLES   = 1024,
  parameter type axi_req_t  = aplic_msi_pkg::axi_req_t,
  parameter type axi_resp_t = aplic_msi_pkg::axi_resp_t,
  localparam int unsigned HART_W  = (NR_HARTS > 1) ? $clog2(NR_HARTS) : 1,
  localparam int unsigned GUEST_W = ($clog2(NR_GUESTS + 1) > 1) ? $clog2(NR_GUESTS + 1) : 1
) (
  input  logic                  i_clk,
  input  logic                  ni_rst,
  input  logic                  i_msi_valid,
  output logic                  o_msi_ready,
  input  logic [HART_W-1:0]     i_hart_idx,
  input  logic [GUEST_W-1:0]    i_guest_idx,
  input  logic [EIID_WIDTH-1:0] i_eiid,
  output axi_req_t              o_req,
  input  axi_resp_t             i_resp,
  output logic                  o_done,
  output logic                  o_err,
  output logic                  o_busy,
  output logic                  o_timeout
);

  state_e state_q, state_d;
  logic [HART_W-1:0]     hart_q;
  logic [GUEST_W-1:0]    guest_q;
  logic [EIID_WIDTH-1:0] eiid_q;
  logic aw_done_q, w_done_q;
  logic aw_valid, w_valid, b_ready, accept;
  logic [AXI_ADDR_WIDTH-1:0] addr;
  logic [31:0]               eiid_word;
  logic [AXI_DW-1:0]         wdata;
  logic [AXI_DW/8-1:0]       wstrb;
  logic                      unused_ok;

  assign o_msi_ready = (state_q == IDLE);
  assign o_busy      = (state_q != IDLE);
  assign accept      = i_msi_valid && o_msi_ready;
  assign unused_ok   = ^i_resp;

  always_ff @(posedge i_clk) begin
    if (!ni_rst) begin
      state_q   <= IDLE;
      hart_q    <= '0;
      guest_q   <= '0;
      eiid_q    <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        hart_q  <= i_hart_idx;
        guest_q <= i_guest_idx;
        eiid_q  <= i_eiid;
      end
      // Per-channel handshake memory so each valid drops independently.
      if (state_q == SEND) begin
        aw_done_q <= aw_done_q || i_resp.aw_ready;
        w_done_q  <= w_done_q  || i_resp.w_ready;
      end else begin
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    aw_valid = 1'b0;
    w_valid  = 1'b0;
    b_ready  = 1'b0;
    o_done   = 1'b0;
    o_err    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_msi_valid) state_d = SEND;
      end
      SEND: begin
        aw_valid = !aw_done_q;
        w_valid  = !w_done_q;
        if ((aw_done_q || i_resp.aw_ready) && (w_done_q || i_resp.w_ready)) state_d = WAIT_B;
      end
      WAIT_B: begin
        b_ready = 1'b1;
        if (i_resp.b_valid) begin
          o_done  = (i_resp.b.resp == RESP_OKAY);
          o_err   = (i_resp.b.resp != RESP_OKAY);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign addr = AXI_ADDR_WIDTH'(BASE_ADDR + msi_offset(64'(hart_q), 64'(guest_q), HART_STRIDE_LOG2));
  assign eiid_word = 32'(eiid_q);

  // EIID rides in the 32-bit lane selected by addr[2].
  if (AXI_DATA_WIDTH == 64) begin : g_dw64
    assign wdata = addr[2] ? {eiid_word, 32'h0} : {32'h0, eiid_word};
    assign wstrb = addr[2] ? 8'hF0 : 8'h0F;
  end else begin : g_dw32
    assign wdata = {32'h0, eiid_word};
    assign wstrb = 8'h0F;
  end

  always_comb begin
    o_req          = '0;
    o_req.aw.id    = AXI_IW'(AXI_ID);
    o_req.aw.addr  = AXI_AW'(addr);
    o_req.aw.len   = 8'd0;
    o_req.aw.size  = SIZE_4B;
    o_req.aw.burst = BURST_INCR;
    o_req.aw_valid = aw_valid;
    o_req.w.data   = wdata;
    o_req.w.strb   = wstrb;
    o_req.w.last   = 1'b1;
    o_req.w_valid  = w_valid;
    o_req.b_ready  = b_ready;
  end

`ifdef APLIC_MSI_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q;
  logic            timeout_q;

  // Down-counter reloaded while in SEND, so it starts full on every WAIT_B entry.
  always_ff @(posedge i_clk) begin
    if (!ni_rst) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else if (state_q == SEND) begin
      to_cnt_q <= TO_W'(TIMEOUT_CYCLES);
    end else if (state_q == WAIT_B && to_cnt_q != '0) begin
      to_cnt_q <= to_cnt_q - TO_W'(1);
      if (to_cnt_q == TO_W'(1)) timeout_q <= 1'b1;
    end
  end

  assign o_timeout = timeout_q;
`else
  assign o_timeout = 1'b0;
`endif

endmodule
